memory_stream_arbiter: RTL and testbench



---
 rtl/memory_stream_arbiter_if.sv | 31 +++
 rtl/memory_stream_arbiter.sv | 140 ++++++++++++++
 tb/tb_memory_stream_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stream_arbiter_if.sv
// AXI-Stream link bundle used by memory_stream_arbiter for both producer and
// consumer sides. The producer drives payload/valid and the consumer drives ready.
interface memory_stream_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_WIDTH-1:0] tstrb;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  // Producer side of the link
  modport master (
    output tdata,
    output tstrb,
    output tvalid,
    output tlast,
    input  tready
  );

  // Consumer side of the link
  modport slave (
    input  tdata,
    input  tstrb,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/memory_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream write port between
// two producers. A grant lasts for a whole packet (through tlast), and beats
// pass through a one-deep registered output stage.
// Build option: define ARB_FIXED_PRIORITY_EN to make s01 win every tie.
module memory_stream_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    axis_aclk,
  input  logic                    axis_areset,
  memory_stream_arbiter_if.slave  s01_axis,
  memory_stream_arbiter_if.slave  s02_axis,
  memory_stream_arbiter_if.master m01_axis,
  output logic                    m01_axis_tsrc
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  last_src_q;
  logic                  tie_src_c;
  logic                  out_free_c;
  logic                  s01_ready_c;
  logic                  s02_ready_c;
  logic                  accept_c;
  logic                  grant_src_c;
  logic [DATA_WIDTH-1:0] in_tdata_c;
  logic [STRB_WIDTH-1:0] in_tstrb_c;
  logic                  in_tlast_c;

  logic [DATA_WIDTH-1:0] tdata_q;
  logic [STRB_WIDTH-1:0] tstrb_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  tsrc_q;

  // Tie-break choice when both producers request in IDLE (0 = s01, 1 = s02)
`ifdef ARB_FIXED_PRIORITY_EN
  assign tie_src_c = 1'b0;
`else
  assign tie_src_c = ~last_src_q;
`endif

  // Next-state, grant steering and beat acceptance
  always_comb begin
    state_d     = state_q;
    s01_ready_c = 1'b0;
    s02_ready_c = 1'b0;
    accept_c    = 1'b0;
    grant_src_c = 1'b0;
    in_tdata_c  = s01_axis.tdata;
    in_tstrb_c  = s01_axis.tstrb;
    in_tlast_c  = s01_axis.tlast;
    out_free_c  = ~tvalid_q | m01_axis.tready;

    case (state_q)
      IDLE: begin
        if (s01_axis.tvalid && s02_axis.tvalid) begin
          state_d = tie_src_c ? GNT2 : GNT1;
        end else if (s01_axis.tvalid) begin
          state_d = GNT1;
        end else if (s02_axis.tvalid) begin
          state_d = GNT2;
        end
      end
      GNT1: begin
        s01_ready_c = out_free_c;
        accept_c    = s01_axis.tvalid & out_free_c;
        if (accept_c && s01_axis.tlast) begin
          state_d = IDLE;
        end
      end
      GNT2: begin
        grant_src_c = 1'b1;
        s02_ready_c = out_free_c;
        in_tdata_c  = s02_axis.tdata;
        in_tstrb_c  = s02_axis.tstrb;
        in_tlast_c  = s02_axis.tlast;
        accept_c    = s02_axis.tvalid & out_free_c;
        if (accept_c && s02_axis.tlast) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Remember who finished the most recent packet; reset favours s01 next
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      last_src_q <= 1'b1;
    end else if (accept_c && in_tlast_c) begin
      last_src_q <= grant_src_c;
    end
  end

  // One-deep output register: load on accept, drain when consumer takes it
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tsrc_q   <= 1'b0;
    end else if (accept_c) begin
      tdata_q  <= in_tdata_c;
      tstrb_q  <= in_tstrb_c;
      tvalid_q <= 1'b1;
      tlast_q  <= in_tlast_c;
      tsrc_q   <= grant_src_c;
    end else if (m01_axis.tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign s01_axis.tready = s01_ready_c;
  assign s02_axis.tready = s02_ready_c;

  assign m01_axis.tdata  = tdata_q;
  assign m01_axis.tstrb  = tstrb_q;
  assign m01_axis.tvalid = tvalid_q;
  assign m01_axis.tlast  = tlast_q;
  assign m01_axis_tsrc   = tsrc_q;
endmodule

// File: tb/tb_memory_stream_arbiter.sv
// Scoreboard bench for memory_stream_arbiter: producers are fed from beat
// queues, the expected output order is derived from packet-level arbitration
// rules, and a monitor pops/compares every beat the DUT hands over.
module tb_memory_stream_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          first;
    logic          last;
    int            gap;
  } beat_t;

  typedef logic [DW+SW+1:0] exp_t;  // {src, last, strb, data}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_stream_arbiter_if #(.DATA_WIDTH(DW)) s01_if ();
  memory_stream_arbiter_if #(.DATA_WIDTH(DW)) s02_if ();
  memory_stream_arbiter_if #(.DATA_WIDTH(DW)) m01_if ();
  logic m_tsrc;

  memory_stream_arbiter #(.DATA_WIDTH(DW)) dut (
    .axis_aclk    (clk),
    .axis_areset  (rst),
    .s01_axis     (s01_if),
    .s02_axis     (s02_if),
    .m01_axis     (m01_if),
    .m01_axis_tsrc(m_tsrc)
  );

  logic [DW-1:0] drv_data  [2];
  logic [SW-1:0] drv_strb  [2];
  logic          drv_valid [2];
  logic          drv_last  [2];
  logic          inflight  [2];
  logic          m_ready;

  assign s01_if.tdata  = drv_data[0];
  assign s01_if.tstrb  = drv_strb[0];
  assign s01_if.tvalid = drv_valid[0];
  assign s01_if.tlast  = drv_last[0];
  assign s02_if.tdata  = drv_data[1];
  assign s02_if.tstrb  = drv_strb[1];
  assign s02_if.tvalid = drv_valid[1];
  assign s02_if.tlast  = drv_last[1];
  assign m01_if.tready = m_ready;

  beat_t src_q0[$];
  beat_t src_q1[$];
  beat_t st_q0[$];
  beat_t st_q1[$];
  exp_t  exp_q[$];
  bit    rdy_pat[$];
  bit    rdy_rand = 1'b0;
  bit    model_last = 1'b1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic bit src_rdy(input int s);
    return (s == 0) ? s01_if.tready : s02_if.tready;
  endfunction

  function automatic int q_size(input int s);
    return (s == 0) ? src_q0.size() : src_q1.size();
  endfunction

  function automatic beat_t q_front(input int s);
    return (s == 0) ? src_q0[0] : src_q1[0];
  endfunction

  // Queue one beat on a producer and stage it for later ordering
  task automatic add_beat(input int s, input logic [DW-1:0] d, input logic [SW-1:0] st,
                          input bit first, input bit last, input int gap);
    beat_t b;
    b.data = d; b.strb = st; b.first = first; b.last = last; b.gap = gap;
    if (s == 0) begin src_q0.push_back(b); st_q0.push_back(b); end
    else        begin src_q1.push_back(b); st_q1.push_back(b); end
  endtask

  // Queue a packet; gap_idx/gap_len drop tvalid before one beat, rnd randomizes everything
  task automatic add_pkt(input int s, input int len, input logic [DW-1:0] d0, input bit rnd,
                         input int gap_idx, input int gap_len);
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] d;
      logic [SW-1:0] st;
      int            g;
      d  = rnd ? DW'($urandom) : d0 + DW'(i);
      st = rnd ? SW'($urandom_range(1, 15)) : SW'(4'hF);
      g  = (i == gap_idx) ? gap_len : 0;
      if (rnd && i > 0) g = $urandom_range(0, 2);
      add_beat(s, d, st, i == 0, i == len - 1, g);
    end
  endtask

  // Append the next staged packet of source s to the expected output order
  task automatic commit(input bit s);
    beat_t b;
    bit    done;
    done = 1'b0;
    while (!done) begin
      if (s == 1'b0) begin
        if (st_q0.size() == 0) break;
        b = st_q0.pop_front();
      end else begin
        if (st_q1.size() == 0) break;
        b = st_q1.pop_front();
      end
      exp_q.push_back({s, b.last, b.strb, b.data});
      done = b.last;
    end
    model_last = s;
  endtask

  function automatic bit tie_winner();
`ifdef ARB_FIXED_PRIORITY_EN
    return 1'b0;
`else
    return ~model_last;
`endif
  endfunction

  // Both producers hold n packets each and keep requesting
  task automatic commit_both(input int n);
`ifdef ARB_FIXED_PRIORITY_EN
    repeat (n) commit(1'b0);
    repeat (n) commit(1'b1);
`else
    bit w;
    w = tie_winner();
    repeat (n) begin
      commit(w);
      commit(~w);
    end
`endif
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_q0.size() != 0 || src_q1.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(n < limit, name, 64'(n), 64'(limit));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_beat(input logic [DW-1:0] d, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m01_if.tvalid && m01_if.tdata == d) && n < 50);
    chk(n < 50, name, 64'(m01_if.tdata), 64'(d));
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk); #1;
  endtask

  // Producer drivers: present queued beats, honour gaps, advance on handshake
  initial begin : drivers
    bit fire    [2];
    bit started [2];
    int wait_left [2];
    beat_t b;
    for (int s = 0; s < 2; s++) begin
      drv_valid[s] = 1'b0; drv_last[s] = 1'b0; drv_data[s] = '0; drv_strb[s] = '0;
      inflight[s] = 1'b0; started[s] = 1'b0; wait_left[s] = 0; fire[s] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) fire[s] = drv_valid[s] && src_rdy(s);
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        if (rst) begin
          drv_valid[s] = 1'b0; started[s] = 1'b0; inflight[s] = 1'b0;
          if (s == 0) src_q0.delete(); else src_q1.delete();
          continue;
        end
        if (fire[s] && q_size(s) > 0) begin
          b = q_front(s);
          if (b.first) inflight[s] = 1'b1;
          if (b.last)  inflight[s] = 1'b0;
          if (s == 0) void'(src_q0.pop_front()); else void'(src_q1.pop_front());
          started[s] = 1'b0;
        end
        if (q_size(s) > 0) begin
          b = q_front(s);
          if (!started[s]) begin wait_left[s] = b.gap; started[s] = 1'b1; end
          if (wait_left[s] > 0) begin
            wait_left[s]--;
            drv_valid[s] = 1'b0;
          end else begin
            drv_valid[s] = 1'b1; drv_data[s] = b.data; drv_strb[s] = b.strb; drv_last[s] = b.last;
          end
        end else begin
          drv_valid[s] = 1'b0;
        end
      end
    end
  end

  // Consumer ready: scripted pattern first, otherwise random or always-ready
  initial begin : ready_drv
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_pat.size() > 0)  m_ready = rdy_pat.pop_front();
      else if (rdy_rand)       m_ready = 1'($urandom_range(0, 1));
      else                     m_ready = 1'b1;
    end
  end

  // Monitor: scoreboard pop on each transfer plus stall/grant rules every cycle
  initial begin : monitor
    exp_t got, prev_got, want;
    bit   prev_stall;
    prev_stall = 1'b0;
    prev_got   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
        continue;
      end
      got = {m_tsrc, m01_if.tlast, m01_if.tstrb, m01_if.tdata};
      if (prev_stall) chk(m01_if.tvalid && got == prev_got, "stall_hold", 64'(got), 64'(prev_got));
      if (m01_if.tvalid && !m_ready)
        chk(!s01_if.tready && !s02_if.tready, "stall_tready",
            64'({s01_if.tready, s02_if.tready}), 64'(0));
      if (inflight[0]) chk(!s02_if.tready, "s02_blocked", 64'(s02_if.tready), 64'(0));
      if (inflight[1]) chk(!s01_if.tready, "s01_blocked", 64'(s01_if.tready), 64'(0));
      if (m01_if.tvalid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", 64'(got), 64'(0));
        end else begin
          want = exp_q.pop_front();
          chk(got == want, "beat", 64'(got), 64'(want));
        end
      end
      prev_stall = m01_if.tvalid && !m_ready;
      prev_got   = got;
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout, want completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   n;
    bit   w;
    logic [3:0] pat;

    // Reset state
    repeat (3) @(negedge clk);
    chk(m01_if.tvalid == 1'b0 && m01_if.tlast == 1'b0 && m_tsrc == 1'b0,
        "rst_ctrl", 64'({m01_if.tvalid, m01_if.tlast, m_tsrc}), 64'(0));
    chk(m01_if.tdata == '0 && m01_if.tstrb == '0, "rst_data",
        64'({m01_if.tstrb, m01_if.tdata}), 64'(0));
    chk(!s01_if.tready && !s02_if.tready, "rst_tready",
        64'({s01_if.tready, s02_if.tready}), 64'(0));
    rst = 1'b0;
    @(negedge clk); #1;

    // Single s01 packet: latency and back-to-back beats
    add_beat(0, 32'h55, 4'hF, 1'b1, 1'b0, 0);
    add_beat(0, 32'h22, 4'hF, 1'b0, 1'b0, 0);
    add_beat(0, 32'h24, 4'hF, 1'b0, 1'b1, 0);
    commit(1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!drv_valid[0] && n < 20);
    chk(m01_if.tvalid == 1'b0, "lat_n0", 64'(m01_if.tvalid), 64'(0));
    @(negedge clk);
    chk(m01_if.tvalid == 1'b0, "lat_n1", 64'(m01_if.tvalid), 64'(0));
    @(negedge clk);
    chk(m01_if.tvalid && m01_if.tdata == 32'h55 && !m01_if.tlast, "lat_n2",
        64'({m01_if.tvalid, m01_if.tdata}), 64'({1'b1, 32'h55}));
    @(negedge clk);
    chk(m01_if.tvalid && m01_if.tdata == 32'h22 && !m01_if.tlast, "beat2_next",
        64'({m01_if.tvalid, m01_if.tdata}), 64'({1'b1, 32'h22}));
    @(negedge clk);
    chk(m01_if.tvalid && m01_if.tdata == 32'h24 && m01_if.tlast, "beat3_last",
        64'({m01_if.tvalid, m01_if.tlast, m01_if.tdata}), 64'({2'b11, 32'h24}));
    wait_drain("drain_t1", 200);

    // Simultaneous 2-beat packets after reset: s01 first, one bubble, then s02
    do_reset();
    add_pkt(0, 2, 32'h11, 1'b0, -1, 0);
    add_pkt(1, 2, 32'h21, 1'b0, -1, 0);
    w = tie_winner();
    commit(w);
    commit(~w);
    wait_beat(32'h11, "tie_first");
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(m01_if.tvalid == pat[i], "bubble_pattern", 64'(m01_if.tvalid), 64'(pat[i]));
    end
    wait_drain("drain_t2", 200);

    // Back-to-back ties: two packets per producer
    add_pkt(0, 2, 32'h100, 1'b0, -1, 0);
    add_pkt(0, 2, 32'h110, 1'b0, -1, 0);
    add_pkt(1, 2, 32'h200, 1'b0, -1, 0);
    add_pkt(1, 2, 32'h210, 1'b0, -1, 0);
    commit_both(2);
    wait_drain("drain_t3", 300);

    // Backpressure 1,0,0,1 during a 4-beat s02 packet
    add_pkt(1, 4, 32'h40, 1'b0, -1, 0);
    commit(1'b1);
    wait_beat(32'h40, "bp_start");
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    wait_drain("drain_t4", 200);

    // s01 drops tvalid for 3 cycles mid-packet while s02 waits
    add_pkt(0, 4, 32'h50, 1'b0, 2, 3);
    add_pkt(1, 2, 32'h60, 1'b0, -1, 0);
    w = tie_winner();
    commit(w);
    commit(~w);
    wait_drain("drain_t5", 300);

    // Single-beat s01 packet, then reset during beat 2 of a 4-beat packet
    add_pkt(0, 1, 32'h61, 1'b0, -1, 0);
    commit(1'b0);
    wait_drain("drain_t6a", 100);
    add_pkt(0, 4, 32'h70, 1'b0, -1, 0);
    commit(1'b0);
    wait_beat(32'h71, "rst_beat2");
    #2;
    rst = 1'b1;
    #1;
    chk(m01_if.tvalid == 1'b0, "rst_mid_valid", 64'(m01_if.tvalid), 64'(0));
    chk(!s01_if.tready && !s02_if.tready, "rst_mid_tready",
        64'({s01_if.tready, s02_if.tready}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk); #1;
    add_pkt(0, 1, 32'h81, 1'b0, -1, 0);
    add_pkt(1, 1, 32'h91, 1'b0, -1, 0);
    w = tie_winner();
    commit(w);
    commit(~w);
    wait_drain("drain_t6b", 100);

    // Random traffic: both producers saturated, random ready and mid-packet gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      add_pkt(0, $urandom_range(1, 5), '0, 1'b1, -1, 0);
      add_pkt(1, $urandom_range(1, 5), '0, 1'b1, -1, 0);
    end
    commit_both(6);
    wait_drain("drain_rand", 3000);
    rdy_rand = 1'b0;
    repeat (3) @(negedge clk);

    chk(exp_q.size() == 0, "exp_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
